conv_job_arbiter: RTL and testbench
===================================

# conv_job_arbiter

Job-level arbiter that shares one `conv_8_4`-style convolution datapath between two client streams. A job is N x values in, M f values in, and N-M+1 y results out. The block grants the datapath to one client per job, routes that client's valid/ready streams straight through, and returns results only to the granted client. It sits between two stream producers/consumers and a single datapath instance, and alternates priority round-robin at job granularity.

## Interface
- N, 8, x values per job
- M, 4, f values per job
- W, 8, signed input data width
- OW, 18, signed output data width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state
- cK_data_in_x  in  W  client K x data, K in {0,1}
- cK_valid_x / cK_ready_x  in / out  1  client K x handshake
- cK_data_in_f  in  W  client K f data
- cK_valid_f / cK_ready_f  in / out  1  client K f handshake
- cK_data_out_y  out  OW  client K y data
- cK_valid_y / cK_ready_y  out / in  1  client K y handshake
- d_data_in_x, d_valid_x  out  W, 1  x to datapath
- d_ready_x  in  1  datapath x ready
- d_data_in_f, d_valid_f  out  W, 1  f to datapath
- d_ready_f  in  1  datapath f ready
- d_data_out_y, d_valid_y  in  OW, 1  y from datapath
- d_ready_y  out  1  y accept to datapath
- busy  out  1  job in progress
- grant  out  1  granted client index; meaningful only when busy=1

## Operation
- FSM has two states. IDLE: no transfers on any channel. BUSY: grant g owns the datapath.
- Request from client K: rK = cK_valid_x | cK_valid_f, sampled in IDLE.
- IDLE arbitration: only one rK high, grant that client. Both high, grant the client given by priority pointer `prio` (reset value 0). Neither high, stay in IDLE.
- On grant, clear counters x_cnt, f_cnt, y_cnt and go to BUSY.
- BUSY routing for the granted client g, all combinational, no buffering:
  - d_valid_x = cg_valid_x & (x_cnt<N); cg_ready_x = d_ready_x & (x_cnt<N); d_data_in_x = cg_data_in_x. f channel is identical with f_cnt<M.
  - cg_valid_y = d_valid_y & (y_cnt<N-M+1); d_ready_y = cg_ready_y & (y_cnt<N-M+1); cg_data_out_y = d_data_out_y.
- Each counter increments on a completed handshake at the datapath side.
- Non-granted client, and both clients in IDLE: ready_x=0, ready_f=0, valid_y=0, data_out_y=0. In IDLE, d_valid_x=0, d_valid_f=0, d_ready_y=0, and d_data_in_x/d_data_in_f=0.
- Job completes on the edge where x_cnt=N, f_cnt=M and y_cnt=N-M+1 all hold after that edge's updates. On that edge: state goes to IDLE and prio becomes ~g.
- A d_valid_y asserted while IDLE is held off (d_ready_y=0) and never delivered. Such a y is a datapath fault, not a routing case.
- Counter widths: ceil(log2(N+1)) bits; counters saturate at their terminal value, never wrap.

## Timing
- Reset (reset=0, asynchronous) forces: state IDLE, busy=0, grant=0, prio=0, counters=0, and all ready/valid/data outputs 0. Reset applied mid-job abandons the job; the datapath must be reset by the same signal.
- Grant latency: a request present before edge k in IDLE gives busy=1 after edge k. The first transfer is possible in the cycle following edge k.
- Pass-through adds zero cycles of latency. Combinational paths exist from cK_valid to d_valid and from d_ready to cK_ready, and the reverse for y.
- After completion there is at least one IDLE cycle before the next BUSY.
- Inputs may finish before outputs. busy stays 1 until the last y handshake, however long cg_ready_y is held low.
- A client that deasserts valid mid-job keeps its grant; there is no timeout.

## Test plan
- Reset: hold reset=0 with all client valids=1 → busy=0, every ready=0, d_valid_x=d_valid_f=0, cK_valid_y=0, cK_data_out_y=0.
- Single job, client 0, no backpressure, x=1..8, f=1,0,0,0 → c0 receives y=1,2,3,4,5; c1_valid_y stays 0; busy falls on the edge of the 5th y handshake.
- Both clients request from IDLE at the same time, repeated for 3 jobs → grant order 0,1,0; one IDLE cycle between jobs.
- Client 1 requests while client 0 holds c0_ready_y=0 for 20 cycles after all inputs are sent → c1_ready_x=c1_ready_f=0 throughout; client 1 is granted only after client 0's 5th y.
- Reset pulse after 3 x values accepted in a client-1 job → IDLE, prio=0. Next simultaneous request grants client 0 with fresh counters, and its results match a golden model.
- Random valid/ready bits on every channel each cycle for 1000 jobs per client, checked against a golden convolution model → zero mismatches and no y delivered to the wrong client.

Source files
------------

// File: rtl/conv_job_arbiter_if.sv
// Channel bundle for one convolution job stream.
// x and f flow from master to slave, and y results flow back from slave to master.
interface conv_job_arbiter_if #(
  parameter int W  = 8,
  parameter int OW = 18
);
  logic signed [W-1:0]  data_in_x;
  logic                 valid_x;
  logic                 ready_x;
  logic signed [W-1:0]  data_in_f;
  logic                 valid_f;
  logic                 ready_f;
  logic signed [OW-1:0] data_out_y;
  logic                 valid_y;
  logic                 ready_y;

  modport master (
    output data_in_x, valid_x,
    input  ready_x,
    output data_in_f, valid_f,
    input  ready_f,
    input  data_out_y, valid_y,
    output ready_y
  );

  modport slave (
    input  data_in_x, valid_x,
    output ready_x,
    input  data_in_f, valid_f,
    output ready_f,
    output data_out_y, valid_y,
    input  ready_y
  );
endinterface

// File: rtl/conv_job_arbiter.sv
// Shares one convolution datapath between two clients, granting it one whole job at a time.
// Priority alternates round-robin between jobs.
//   state  | meaning
//   S_IDLE | no job owns the datapath; all channels are closed
//   S_BUSY | client `grant` owns the datapath until its x, f and y counts all finish
module conv_job_arbiter #(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int W  = 8,
  parameter int OW = 18
) (
  input  logic               clk,
  input  logic               reset,
  conv_job_arbiter_if.slave  c0,
  conv_job_arbiter_if.slave  c1,
  conv_job_arbiter_if.master d,
  output logic               busy,
  output logic               grant
);
  localparam int NY = N - M + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] X_TC = CW'(N);
  localparam logic [CW-1:0] F_TC = CW'(M);
  localparam logic [CW-1:0] Y_TC = CW'(NY);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              state;
  logic                prio;
  logic [CW-1:0]       x_cnt, f_cnt, y_cnt;
  logic [CW-1:0]       x_nxt, f_nxt, y_nxt;
  logic                x_open, f_open, y_open;
  logic                x_hs, f_hs, y_hs;
  logic                req0, req1, job_done;
  logic signed [W-1:0] sel_x, sel_f;
  logic                sel_vx, sel_vf, sel_ry;
  logic signed [OW-1:0] y_data;

  assign req0 = c0.valid_x | c0.valid_f;
  assign req1 = c1.valid_x | c1.valid_f;

  assign x_open = (state == S_BUSY) && (x_cnt < X_TC);
  assign f_open = (state == S_BUSY) && (f_cnt < F_TC);
  assign y_open = (state == S_BUSY) && (y_cnt < Y_TC);

  assign sel_x  = grant ? c1.data_in_x : c0.data_in_x;
  assign sel_f  = grant ? c1.data_in_f : c0.data_in_f;
  assign sel_vx = grant ? c1.valid_x   : c0.valid_x;
  assign sel_vf = grant ? c1.valid_f   : c0.valid_f;
  assign sel_ry = grant ? c1.ready_y   : c0.ready_y;
  assign y_data = d.data_out_y;

  // Counters advance only on datapath-side handshakes, which the open flags already gate.
  assign x_hs  = d.valid_x & d.ready_x;
  assign f_hs  = d.valid_f & d.ready_f;
  assign y_hs  = d.valid_y & d.ready_y;
  assign x_nxt = x_cnt + CW'(x_hs);
  assign f_nxt = f_cnt + CW'(f_hs);
  assign y_nxt = y_cnt + CW'(y_hs);
  assign job_done = (x_nxt == X_TC) && (f_nxt == F_TC) && (y_nxt == Y_TC);

  always_comb begin
    d.data_in_x   = '0;
    d.valid_x     = 1'b0;
    d.data_in_f   = '0;
    d.valid_f     = 1'b0;
    d.ready_y     = 1'b0;
    c0.ready_x    = 1'b0;
    c0.ready_f    = 1'b0;
    c0.valid_y    = 1'b0;
    c0.data_out_y = '0;
    c1.ready_x    = 1'b0;
    c1.ready_f    = 1'b0;
    c1.valid_y    = 1'b0;
    c1.data_out_y = '0;
    if (state == S_BUSY) begin
      d.data_in_x = sel_x;
      d.valid_x   = sel_vx & x_open;
      d.data_in_f = sel_f;
      d.valid_f   = sel_vf & f_open;
      d.ready_y   = sel_ry & y_open;
      if (grant) begin
        c1.ready_x    = d.ready_x & x_open;
        c1.ready_f    = d.ready_f & f_open;
        c1.valid_y    = d.valid_y & y_open;
        c1.data_out_y = y_data;
      end else begin
        c0.ready_x    = d.ready_x & x_open;
        c0.ready_f    = d.ready_f & f_open;
        c0.valid_y    = d.valid_y & y_open;
        c0.data_out_y = y_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      grant <= 1'b0;
      prio  <= 1'b0;
      x_cnt <= '0;
      f_cnt <= '0;
      y_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            state <= S_BUSY;
            busy  <= 1'b1;
            grant <= (req0 & req1) ? prio : req1;
            x_cnt <= '0;
            f_cnt <= '0;
            y_cnt <= '0;
          end
        end
        S_BUSY: begin
          x_cnt <= x_nxt;
          f_cnt <= f_nxt;
          y_cnt <= y_nxt;
          if (job_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            prio  <= ~grant;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_job_arbiter.sv
// Two random client streams and a datapath stub around conv_job_arbiter.
// Results are scored against a convolution model; grant order is scored against a round-robin model.
module tb_conv_job_arbiter;
  localparam int N  = 8;
  localparam int M  = 4;
  localparam int W  = 8;
  localparam int OW = 18;
  localparam int NY = N - M + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, grant;
  always #5 clk = ~clk;

  conv_job_arbiter_if #(.W(W), .OW(OW)) c0_if ();
  conv_job_arbiter_if #(.W(W), .OW(OW)) c1_if ();
  conv_job_arbiter_if #(.W(W), .OW(OW)) d_if ();

  conv_job_arbiter #(.N(N), .M(M), .W(W), .OW(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .c0    (c0_if),
    .c1    (c1_if),
    .d     (d_if),
    .busy  (busy),
    .grant (grant)
  );

  int checks = 0;
  int errors = 0;

  int xq[2][$];
  int fq[2][$];
  int exp_q[2][$];
  int grant_log[$];
  int xsent[2];
  bit en[2];
  bit rnd_mode = 1'b0;
  bit hold_y0 = 1'b0;

  int job_x[N];
  int job_f[M];

  int dp_x[N];
  int dp_f[M];
  int dp_y[NY];
  int dp_xn = 0, dp_fn = 0, dp_yn = 0;

  function automatic bit coin();
    if (!rnd_mode) return 1'b1;
    return ($urandom_range(99) < 80);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus push: the golden results for the job go onto the client's scoreboard queue.
  task automatic add_job(input int k);
    for (int i = 0; i < N; i++) xq[k].push_back(job_x[i]);
    for (int j = 0; j < M; j++) fq[k].push_back(job_f[j]);
    for (int i = 0; i < NY; i++) begin
      int s;
      s = 0;
      for (int j = 0; j < M; j++) s += job_x[i + j] * job_f[j];
      exp_q[k].push_back(s);
    end
  endtask

  task automatic add_rand_job(input int k);
    for (int i = 0; i < N; i++) job_x[i] = int'($urandom_range(255)) - 128;
    for (int j = 0; j < M; j++) job_f[j] = int'($urandom_range(255)) - 128;
    add_job(k);
  endtask

  task automatic flush();
    for (int k = 0; k < 2; k++) begin
      xq[k].delete();
      fq[k].delete();
      exp_q[k].delete();
    end
    dp_xn = 0;
    dp_fn = 0;
    dp_yn = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy) && n < budget);
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: pending y c0=%0d c1=%0d busy=%0b after %0d cycles, required none pending",
               tag, exp_q[0].size(), exp_q[1].size(), busy, n);
    end
  endtask

  task automatic check_y(input int k, input int act);
    int e;
    checks++;
    if (exp_q[k].size() == 0) begin
      errors++;
      $display("FAIL y_unexpected_c%0d: got y=%0d with nothing expected", k, act);
    end else begin
      e = exp_q[k].pop_front();
      if (act != e) begin
        errors++;
        $display("FAIL y_data_c%0d: got %0d expected %0d", k, act, e);
      end
    end
  endtask

  // Clients and datapath stub: drive after the falling edge, commit handshakes just before the rising edge.
  initial begin : driver
    forever begin
      @(negedge clk);
      c0_if.valid_x   = en[0] && (xq[0].size() != 0) && coin();
      c0_if.data_in_x = (xq[0].size() != 0) ? W'(xq[0][0]) : '0;
      c0_if.valid_f   = en[0] && (fq[0].size() != 0) && coin();
      c0_if.data_in_f = (fq[0].size() != 0) ? W'(fq[0][0]) : '0;
      c0_if.ready_y   = !hold_y0 && coin();
      c1_if.valid_x   = en[1] && (xq[1].size() != 0) && coin();
      c1_if.data_in_x = (xq[1].size() != 0) ? W'(xq[1][0]) : '0;
      c1_if.valid_f   = en[1] && (fq[1].size() != 0) && coin();
      c1_if.data_in_f = (fq[1].size() != 0) ? W'(fq[1][0]) : '0;
      c1_if.ready_y   = coin();
      d_if.ready_x    = coin();
      d_if.ready_f    = coin();
      if (dp_xn == N && dp_fn == M && dp_yn < NY) begin
        d_if.valid_y    = coin();
        d_if.data_out_y = OW'(dp_y[dp_yn]);
      end else begin
        d_if.valid_y    = 1'b0;
        d_if.data_out_y = '0;
      end
      #4;
      if (!reset) begin
        dp_xn = 0;
        dp_fn = 0;
        dp_yn = 0;
      end else begin
        if (c0_if.valid_x && c0_if.ready_x) begin void'(xq[0].pop_front()); xsent[0]++; end
        if (c0_if.valid_f && c0_if.ready_f) void'(fq[0].pop_front());
        if (c1_if.valid_x && c1_if.ready_x) begin void'(xq[1].pop_front()); xsent[1]++; end
        if (c1_if.valid_f && c1_if.ready_f) void'(fq[1].pop_front());
        if (d_if.valid_x && d_if.ready_x) begin
          checks++;
          if (dp_xn >= N) begin
            errors++;
            $display("FAIL dp_x_overfill: got x number %0d in one job, required at most %0d", dp_xn + 1, N);
          end else begin
            dp_x[dp_xn] = int'(d_if.data_in_x);
            dp_xn++;
          end
        end
        if (d_if.valid_f && d_if.ready_f) begin
          checks++;
          if (dp_fn >= M) begin
            errors++;
            $display("FAIL dp_f_overfill: got f number %0d in one job, required at most %0d", dp_fn + 1, M);
          end else begin
            dp_f[dp_fn] = int'(d_if.data_in_f);
            dp_fn++;
          end
        end
        if (d_if.valid_y && d_if.ready_y) begin
          dp_yn++;
          if (dp_yn == NY) begin
            dp_xn = 0;
            dp_fn = 0;
            dp_yn = 0;
          end
        end
        if (dp_xn == N && dp_fn == M && dp_yn == 0) begin
          for (int i = 0; i < NY; i++) begin
            dp_y[i] = 0;
            for (int j = 0; j < M; j++) dp_y[i] += dp_x[i + j] * dp_f[j];
          end
        end
      end
    end
  end

  // Monitor: scoreboard for y, round-robin grant model, job-completion timing and channel isolation.
  initial begin : monitor
    bit prev_busy = 1'b0, done_flag = 1'b0, req_prev = 1'b0, prio_m = 1'b0, exp_g = 1'b0, g_cur = 1'b0;
    bit r0, r1, bad;
    int jx = 0, jf = 0, jy = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        prev_busy = 1'b0;
        done_flag = 1'b0;
        req_prev  = 1'b0;
        prio_m    = 1'b0;
      end else begin
        if (c0_if.valid_y && c0_if.ready_y) check_y(0, int'(c0_if.data_out_y));
        if (c1_if.valid_y && c1_if.ready_y) check_y(1, int'(c1_if.data_out_y));

        if (prev_busy) begin
          checks++;
          if (done_flag && busy) begin
            errors++;
            $display("FAIL busy_after_done: got busy=1 expected 0 after final handshake");
          end else if (!done_flag && !busy) begin
            errors++;
            $display("FAIL busy_early_drop: got busy=0 with x=%0d f=%0d y=%0d, required %0d/%0d/%0d", jx, jf, jy, N, M, NY);
          end
          if (!busy) prio_m = ~g_cur;
        end else if (busy) begin
          checks++;
          grant_log.push_back(int'(grant));
          if (!req_prev || grant != exp_g) begin
            errors++;
            $display("FAIL grant_choice: got grant=%0d expected %0d (request seen=%0b)", grant, exp_g, req_prev);
          end
          jx = 0;
          jf = 0;
          jy = 0;
        end else if (req_prev) begin
          checks++;
          errors++;
          $display("FAIL grant_missing: got busy=0 expected 1 after a request in idle");
        end

        if (!busy) begin
          r0 = c0_if.valid_x | c0_if.valid_f;
          r1 = c1_if.valid_x | c1_if.valid_f;
          exp_g = (r0 && r1) ? prio_m : r1;
          req_prev = r0 | r1;
          done_flag = 1'b0;
        end else begin
          req_prev = 1'b0;
          g_cur = grant;
          jx += (d_if.valid_x && d_if.ready_x) ? 1 : 0;
          jf += (d_if.valid_f && d_if.ready_f) ? 1 : 0;
          jy += (d_if.valid_y && d_if.ready_y) ? 1 : 0;
          done_flag = (jx == N) && (jf == M) && (jy == NY);
        end

        if (!busy)
          bad = c0_if.ready_x || c0_if.ready_f || c0_if.valid_y || (c0_if.data_out_y != '0) ||
                c1_if.ready_x || c1_if.ready_f || c1_if.valid_y || (c1_if.data_out_y != '0) ||
                d_if.valid_x || d_if.valid_f || d_if.ready_y ||
                (d_if.data_in_x != '0) || (d_if.data_in_f != '0);
        else if (grant)
          bad = c0_if.ready_x || c0_if.ready_f || c0_if.valid_y || (c0_if.data_out_y != '0);
        else
          bad = c1_if.ready_x || c1_if.ready_f || c1_if.valid_y || (c1_if.data_out_y != '0);
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL isolation: busy=%0b grant=%0d got a live channel on a client not granted, required all closed", busy, grant);
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : main
    int base, sz, start, n;
    int order[3];
    en[0] = 1'b0;
    en[1] = 1'b0;
    xsent[0] = 0;
    xsent[1] = 0;

    // Reset held with both clients requesting.
    reset = 1'b0;
    add_rand_job(0);
    add_rand_job(1);
    en[0] = 1'b1;
    en[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_c0_ready_x", c0_if.ready_x, 0);
    chk("rst_c0_ready_f", c0_if.ready_f, 0);
    chk("rst_c0_valid_y", c0_if.valid_y, 0);
    chk("rst_c0_data_y", int'(c0_if.data_out_y), 0);
    chk("rst_c1_ready_x", c1_if.ready_x, 0);
    chk("rst_c1_ready_f", c1_if.ready_f, 0);
    chk("rst_c1_valid_y", c1_if.valid_y, 0);
    chk("rst_c1_data_y", int'(c1_if.data_out_y), 0);
    chk("rst_d_valid_x", d_if.valid_x, 0);
    chk("rst_d_valid_f", d_if.valid_f, 0);
    chk("rst_d_ready_y", d_if.ready_y, 0);
    chk("rst_d_data_x", int'(d_if.data_in_x), 0);
    chk("rst_d_data_f", int'(d_if.data_in_f), 0);
    flush();
    #1 reset = 1'b1;

    // Single job on client 0: x=1..8, f=1,0,0,0 gives y=1..5.
    for (int i = 0; i < N; i++) job_x[i] = i + 1;
    job_f[0] = 1;
    for (int j = 1; j < M; j++) job_f[j] = 0;
    base = grant_log.size();
    add_job(0);
    wait_done(300, "single");
    chk("single_jobs", grant_log.size() - base, 1);
    if (grant_log.size() > base) chk("single_grant", grant_log[base], 0);

    // Simultaneous requests from reset: order 0,1,0.
    pulse_reset();
    base = grant_log.size();
    add_rand_job(0);
    add_rand_job(0);
    add_rand_job(1);
    wait_done(600, "rr");
    order[0] = 0;
    order[1] = 1;
    order[2] = 0;
    chk("rr_jobs", grant_log.size() - base, 3);
    for (int i = 0; i < 3; i++)
      if (grant_log.size() > base + i) chk($sformatf("rr_order_%0d", i), grant_log[base + i], order[i]);

    // Client 0 stalls its y; client 1 must wait for the whole job.
    hold_y0 = 1'b1;
    add_rand_job(0);
    n = 0;
    while ((xq[0].size() != 0 || fq[0].size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_inputs_sent", xq[0].size() + fq[0].size(), 0);
    add_rand_job(1);
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("hold_c1_ready_x", c1_if.ready_x, 0);
      chk("hold_c1_ready_f", c1_if.ready_f, 0);
    end
    chk("hold_busy", busy, 1);
    chk("hold_grant", grant, 0);
    hold_y0 = 1'b0;
    wait_done(400, "hold");
    sz = grant_log.size();
    chk("hold_first", grant_log[sz - 2], 0);
    chk("hold_second", grant_log[sz - 1], 1);

    // Leave prio pointing at client 1, then abandon a client-1 job after 3 x values.
    add_rand_job(0);
    wait_done(300, "pre_reset");
    add_rand_job(1);
    start = xsent[1];
    n = 0;
    while (xsent[1] < start + 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("midjob_x_sent", xsent[1] - start, 3);
    #1 reset = 1'b0;
    flush();
    @(posedge clk);
    #1;
    chk("midjob_rst_busy", busy, 0);
    chk("midjob_rst_grant", grant, 0);
    chk("midjob_rst_c1_ready_x", c1_if.ready_x, 0);
    reset = 1'b1;
    base = grant_log.size();
    add_rand_job(0);
    add_rand_job(1);
    wait_done(400, "after_reset");
    chk("after_reset_jobs", grant_log.size() - base, 2);
    if (grant_log.size() > base + 1) begin
      chk("after_reset_first", grant_log[base], 0);
      chk("after_reset_second", grant_log[base + 1], 1);
    end

    // Random valid/ready on every channel.
    rnd_mode = 1'b1;
    base = grant_log.size();
    for (int i = 0; i < 1000; i++) begin
      add_rand_job(0);
      add_rand_job(1);
    end
    wait_done(90000, "random");
    chk("random_jobs", grant_log.size() - base, 2000);
    rnd_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
